// File: rtl/belt_mp_if.sv
// -----------------------------------------------------------------------------
// belt_mp_if
//
// Bundle of drop-side and read-side signals for the multi-port belt.
//
//   flush   discard all live entries (this cycle's drops survive)
//   drop    per-lane drop enable, DROPS bits
//   wdata   lane i data at [i*WIDTH +: WIDTH]
//   rpos    port j belt position at [j*PW +: PW], 0 = newest
//   rdata   port j registered read data at [j*WIDTH +: WIDTH]
//   rvalid  port j: requested position held a live entry
//   count   live entries, saturating at DEPTH
//
// Modports:
//   master  retire/fetch side: drives flush/drop/wdata/rpos, sees results
//   slave   the belt itself
// -----------------------------------------------------------------------------
interface belt_mp_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int DROPS = 2,
    parameter int READS = 2
);
    localparam int PW = $clog2(DEPTH);

    logic                   flush;
    logic [DROPS-1:0]       drop;
    logic [DROPS*WIDTH-1:0] wdata;
    logic [READS*PW-1:0]    rpos;
    logic [READS*WIDTH-1:0] rdata;
    logic [READS-1:0]       rvalid;
    logic [PW:0]            count;

    modport master (
        output flush,
        output drop,
        output wdata,
        output rpos,
        input  rdata,
        input  rvalid,
        input  count
    );

    modport slave (
        input  flush,
        input  drop,
        input  wdata,
        input  rpos,
        output rdata,
        output rvalid,
        output count
    );
endinterface

// File: rtl/belt_mp.sv
// -----------------------------------------------------------------------------
// belt_mp
//
// Multi-port belt: a circular operand store where the newest result sits at
// position 0 and older results age toward position DEPTH-1. Up to DROPS
// results may be dropped per cycle and READS independent ports read the belt
// with one cycle of latency.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset (head, count, rdata, rvalid -> 0)
//   bus   belt_mp_if.slave: flush, drop, wdata, rpos in; rdata, rvalid, count out
//
// Storage model: head points at the next slot to write; the entry at belt
// position p lives at slot (head - 1 - p) mod DEPTH. Storage itself is never
// reset, only the bookkeeping around it.
// -----------------------------------------------------------------------------
module belt_mp #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int DROPS = 2,
    parameter int READS = 2
) (
    input  logic      clk,
    input  logic      rst,
    belt_mp_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    // count plus one cycle of drops can reach 2*DEPTH, one extra bit covers it
    localparam logic [PW+1:0] DEPTH_SUM = (PW+2)'(DEPTH);

    // -------------------------------------------------------------------------
    // Storage and state
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    head_q,   head_d;
    logic [PW:0]      count_q,  count_d;
    logic [WIDTH-1:0] rdata_q  [READS];
    logic [WIDTH-1:0] rdata_d  [READS];
    logic [READS-1:0] rvalid_q, rvalid_d;

    // -------------------------------------------------------------------------
    // Unpack the flat lane / port buses
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] lane_data [DROPS];
    logic [PW-1:0]    port_pos  [READS];

    for (genvar gi = 0; gi < DROPS; gi++) begin : g_lane_unpack
        assign lane_data[gi] = bus.wdata[gi*WIDTH +: WIDTH];
    end

    for (genvar gi = 0; gi < READS; gi++) begin : g_port_unpack
        assign port_pos[gi] = bus.rpos[gi*PW +: PW];
    end

    // -------------------------------------------------------------------------
    // Drop packing: active lanes take consecutive slots starting at head, in
    // ascending lane order, so the highest active lane ends up newest.
    // -------------------------------------------------------------------------
    logic [PW-1:0] lane_slot [DROPS];
    logic [PW:0]   drop_n;

    always_comb begin
        logic [PW:0] acc;
        acc = '0;
        for (int i = 0; i < DROPS; i++) begin
            // acc < DROPS <= DEPTH here, so the low PW bits are the full offset
            lane_slot[i] = head_q + acc[PW-1:0];
            acc          = acc + {{PW{1'b0}}, bus.drop[i]};
        end
        drop_n = acc;
    end

    // -------------------------------------------------------------------------
    // Next-state: head, count, read ports
    // -------------------------------------------------------------------------
    logic [PW+1:0] count_sum;

    always_comb begin
        // drop_n == DEPTH wraps to a zero advance, which is the correct modulo
        head_d    = head_q + drop_n[PW-1:0];

        count_sum = {1'b0, count_q} + {1'b0, drop_n};
        count_d   = count_q;
        if (bus.flush) begin
            // drops in a flush cycle are newer than the flush and survive
            count_d = drop_n;
        end else if (count_sum > DEPTH_SUM) begin
            // overflow is silent: oldest entries were overwritten
            count_d = (PW+1)'(DEPTH);
        end else begin
            count_d = count_sum[PW:0];
        end

        // Reads use pre-edge head, storage and count; a same-cycle drop is
        // not bypassed. Data is returned even for dead positions.
        for (int j = 0; j < READS; j++) begin
            rdata_d[j]  = mem[head_q - PW'(1) - port_pos[j]];
            rvalid_d[j] = ({1'b0, port_pos[j]} < count_q);
        end
    end

    // -------------------------------------------------------------------------
    // Storage write. No reset on the array; the rst gate only keeps a drop
    // coincident with reset from landing.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DROPS; i++) begin
                if (bus.drop[i]) begin
                    mem[lane_slot[i]] <= lane_data[i];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Bookkeeping and read registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            count_q  <= '0;
            rvalid_q <= '0;
            for (int j = 0; j < READS; j++) begin
                rdata_q[j] <= '0;
            end
        end else begin
            head_q   <= head_d;
            count_q  <= count_d;
            rvalid_q <= rvalid_d;
            for (int j = 0; j < READS; j++) begin
                rdata_q[j] <= rdata_d[j];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < READS; gi++) begin : g_port_pack
        assign bus.rdata[gi*WIDTH +: WIDTH] = rdata_q[gi];
    end

    assign bus.rvalid = rvalid_q;
    assign bus.count  = count_q;

endmodule

// File: tb/tb_belt_mp.sv
// -----------------------------------------------------------------------------
// tb_belt_mp
//
// Directed bench for belt_mp with WIDTH=32, DEPTH=16, DROPS=2, READS=2.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_belt_mp;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int DROPS = 2;
    localparam int READS = 2;

    logic clk;
    logic rst;

    int total;
    int bad;

    belt_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROPS(DROPS), .READS(READS)) bus ();

    belt_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROPS(DROPS), .READS(READS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_drop(input logic [1:0] mask, input logic [31:0] d0, input logic [31:0] d1);
        bus.drop  = mask;
        bus.wdata = {d1, d0};
    endtask

    task automatic set_rpos(input logic [3:0] p0, input logic [3:0] p1);
        bus.rpos = {p1, p0};
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.flush = 1'b0;
        set_drop(2'b00, 32'h0, 32'h0);
        set_rpos(4'd0, 4'd0);

        tick();
        tick();
        rst = 1'b0;
        chk("reset_count", 32'(bus.count), 32'd0);
        chk("reset_rvalid", 32'(bus.rvalid), 32'd0);
        chk("reset_rdata0", bus.rdata[31:0], 32'd0);

        // Load something so the asynchronous reset has state to clear
        set_drop(2'b01, 32'h99, 32'h0);
        tick();
        set_drop(2'b00, 32'h0, 32'h0);
        set_rpos(4'd0, 4'd0);
        tick();
        chk("pre_rst_rdata0", bus.rdata[31:0], 32'h99);
        chk("pre_rst_rvalid", 32'(bus.rvalid), 32'd3);

        // Mid-cycle asynchronous reset: outputs clear before the next edge
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_rdata0", bus.rdata[31:0], 32'd0);
        chk("async_rst_rdata1", bus.rdata[63:32], 32'd0);
        chk("async_rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("async_rst_count", 32'(bus.count), 32'd0);
        #2;
        rst = 1'b0;

        // Single-lane fill 1..5
        set_rpos(4'd0, 4'd4);
        for (int v = 1; v <= 5; v++) begin
            set_drop(2'b01, 32'(v), 32'h0);
            tick();
        end
        set_drop(2'b00, 32'h0, 32'h0);
        tick();
        chk("fill_rdata0", bus.rdata[31:0], 32'd5);
        chk("fill_rdata1", bus.rdata[63:32], 32'd1);
        chk("fill_rvalid", 32'(bus.rvalid), 32'd3);
        chk("fill_count", 32'(bus.count), 32'd5);

        // Dual drop ordering: lane1 is newest
        pulse_reset();
        set_drop(2'b11, 32'hA, 32'hB);
        tick();
        chk("dual_count", 32'(bus.count), 32'd2);
        set_drop(2'b00, 32'h0, 32'h0);
        set_rpos(4'd0, 4'd1);
        tick();
        chk("dual_rdata0", bus.rdata[31:0], 32'hB);
        chk("dual_rdata1", bus.rdata[63:32], 32'hA);
        chk("dual_rvalid", 32'(bus.rvalid), 32'd3);
        set_rpos(4'd2, 4'd0);
        tick();
        chk("dual_pos2_rvalid", 32'(bus.rvalid), 32'd2);
        chk("dual_pos0_rdata1", bus.rdata[63:32], 32'hB);

        // Wrap and saturation: 20 single drops 0..19
        pulse_reset();
        for (int v = 0; v < 20; v++) begin
            set_drop(2'b01, 32'(v), 32'h0);
            tick();
        end
        chk("wrap_count", 32'(bus.count), 32'd16);
        set_drop(2'b00, 32'h0, 32'h0);
        set_rpos(4'd0, 4'd15);
        tick();
        chk("wrap_rdata0", bus.rdata[31:0], 32'd19);
        chk("wrap_rdata1", bus.rdata[63:32], 32'd4);
        chk("wrap_rvalid", 32'(bus.rvalid), 32'd3);

        // Sparse mask 2'b10: only lane1 lands, in slot head (=4 after wrap)
        set_drop(2'b10, 32'hDEAD, 32'h100);
        tick();
        chk("sparse_count_sat", 32'(bus.count), 32'd16);
        set_drop(2'b00, 32'h0, 32'h0);
        set_rpos(4'd0, 4'd1);
        tick();
        chk("sparse_rdata0", bus.rdata[31:0], 32'h100);
        chk("sparse_rdata1", bus.rdata[63:32], 32'd19);
        set_rpos(4'd0, 4'd15);
        tick();
        chk("sparse_oldest", bus.rdata[63:32], 32'd5);

        // Flush with concurrent drop
        pulse_reset();
        set_drop(2'b11, 32'd1, 32'd2);
        tick();
        set_drop(2'b11, 32'd3, 32'd4);
        tick();
        set_drop(2'b11, 32'd5, 32'd6);
        tick();
        chk("preflush_count", 32'(bus.count), 32'd6);
        bus.flush = 1'b1;
        set_drop(2'b01, 32'h77, 32'h0);
        set_rpos(4'd5, 4'd6);
        tick();
        chk("flush_count", 32'(bus.count), 32'd1);
        chk("flush_read_rvalid", 32'(bus.rvalid), 32'd1);
        chk("flush_read_rdata0", bus.rdata[31:0], 32'd1);
        bus.flush = 1'b0;
        set_drop(2'b00, 32'h0, 32'h0);
        set_rpos(4'd0, 4'd1);
        tick();
        chk("postflush_rdata0", bus.rdata[31:0], 32'h77);
        chk("postflush_rvalid", 32'(bus.rvalid), 32'd1);

        // Read during drop: no bypass
        set_drop(2'b01, 32'h44, 32'h0);
        tick();
        set_drop(2'b01, 32'h55, 32'h0);
        set_rpos(4'd0, 4'd0);
        tick();
        chk("rdd_rdata0_old", bus.rdata[31:0], 32'h44);
        chk("rdd_count", 32'(bus.count), 32'd3);
        set_drop(2'b00, 32'h0, 32'h0);
        tick();
        chk("rdd_rdata0_new", bus.rdata[31:0], 32'h55);

        // Flush with no drops empties the belt
        bus.flush = 1'b1;
        tick();
        chk("empty_flush_count", 32'(bus.count), 32'd0);
        bus.flush = 1'b0;
        tick();
        chk("empty_flush_rvalid", 32'(bus.rvalid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/belt_mp.md
Name: belt_mp

Overview:
- Parametrised multi-port belt: a circular operand store in which the newest result is always at position 0 and older results age toward position DEPTH-1.
- Generalises the single-drop, two-read belt:
  - up to DROPS results dropped per cycle;
  - READS independent registered read ports;
  - occupancy tracking with per-port valid flags;
  - synchronous flush for frame/branch discard.
- Sits between the functional-unit retire stage (drop side) and operand fetch (read side).

Parameters:
- WIDTH, 32, data width of each belt entry.
- DEPTH, 16, number of entries; power of two, >= 2.
- DROPS, 2, drop lanes per cycle; 1 <= DROPS <= DEPTH.
- READS, 2, read ports; >= 1.
- PW, $clog2(DEPTH), position/index width (localparam, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  discard all belt contents (synchronous).
- drop  in  DROPS  per-lane drop enable; lane i active when drop[i]=1.
- wdata  in  DROPS*WIDTH  lane i data at [i*WIDTH +: WIDTH].
- rpos  in  READS*PW  port j belt position at [j*PW +: PW]; 0 = newest.
- rdata  out  READS*WIDTH  port j registered read data.
- rvalid  out  READS  port j: requested position held a live entry.
- count  out  PW+1  live entries, saturating at DEPTH.

Behaviour:
- Reset is asynchronous and active-high: clk is the single clock; rst acts immediately without waiting for an edge.
- On rst assertion:
  - head index = 0, count = 0, rdata = 0, rvalid = 0.
  - Storage array is not reset; its contents are undefined.
- rst mid-operation: in-flight drops and reads are discarded; first post-reset edge behaves as from empty.
- State:
  - head (PW bits) = next slot to write.
  - Entry at position p lives at slot (head - 1 - p) mod DEPTH.
- Drops, each rising edge with rst low:
  - Active lanes are packed in ascending lane order: active lane i writes slot (head + k) mod DEPTH, where k = number of active lanes below i.
  - head advances by n = popcount(drop), modulo DEPTH (wrap-around natural).
  - Highest-numbered active lane becomes position 0; lower active lanes follow at positions 1, 2, ... in descending lane order.
  - Sparse drop masks are legal (e.g. 2'b10 drops only lane 1 into slot head).
  - drop = 0: no write, head unchanged.
- Reads:
  - Port j registers rdata_j = storage[(head - 1 - rpos_j) mod DEPTH] using the pre-edge head and storage.
  - One-cycle latency; no bypass: a same-cycle drop is not visible until the next read.
  - rvalid_j registered = (rpos_j < count), using pre-edge count.
  - When rvalid_j = 0, rdata_j is still the indexed slot contents (not forced to 0).
  - Reads occur every cycle; there is no read enable.
- Count:
  - count_next = min(DEPTH, count + n), where n is this cycle's popcount.
  - Overflow is silent: oldest entries are overwritten; count saturates at DEPTH.
- Flush:
  - Sets count to n (this cycle's drops survive and are logically newer than the flush).
  - head is NOT reset; drops write normally.
  - Reads in the flush cycle use pre-flush count.
- Priority: rst > flush > drop. Reads are always evaluated against pre-edge state.
- Multiple read ports may address the same position; no conflicts, no stalls, no backpressure.

Test Plan:
- Reset then idle: assert rst asynchronously mid-cycle → rdata=0, rvalid=0, count=0 immediately, before the next edge.
- Single-lane fill (DROPS=2, READS=2): drop=2'b01 with values 1..5 on successive cycles, rpos0=0, rpos1=4 → one cycle after the 5th drop: rdata0=5, rdata1=1, rvalid=2'b11, count=5.
- Dual drop ordering: from empty, drop=2'b11, lane0=0xA, lane1=0xB; next cycle rpos0=0, rpos1=1 → rdata0=0xB, rdata1=0xA; count=2. Same cycle rpos=2 → rvalid=0.
- Wrap and saturation (DEPTH=16): drop 20 single values 0..19 → count=16; rpos=0 reads 19, rpos=15 reads 4, rvalid=1; head wrapped to 4.
- Flush with concurrent drop: belt holds 6 entries, flush=1 with drop=2'b01 value 0x77 → count=1; next read rpos=0 gives 0x77 rvalid=1; rpos=1 gives rvalid=0.
- Read-during-drop: drop 0x55 while rpos0=0 and belt newest=0x44 → registered rdata0=0x44 that cycle; following cycle rdata0=0x55.
